// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised CPU core: opcodes, instruction
// field positions, ALU operation encoding and control-state encoding.
package cpu_pkg;

   // Opcodes live in INSTRUCTION[31:24]
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   // Instruction field LSB positions
   localparam int OPC_LSB  = 24;
   localparam int DEST_LSB = 16;
   localparam int SRC1_LSB = 8;
   localparam int SRC2_LSB = 0;
   localparam int IMM_LSB  = 0;
   localparam int OFF_LSB  = 16;
   localparam int IMM_W    = 8;
   localparam int OFF_W    = 8;
   localparam int OPC_W    = 8;

   // ALU operation selected by decode
   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4
   } alu_op_t;

   // Control state of the core
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // True for opcodes whose result updates the ZERO flag
   function automatic logic op_sets_zero(input logic [7:0] opc);
      return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two combinational read ports, one write port committed on
// the rising edge, synchronous clear of every register on RESET.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RA_W   = 3
)(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   raddr1,
   input  logic [RA_W-1:0]   raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   localparam int NUM_REGS = 2 ** RA_W;

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Clear all registers on reset, otherwise commit the single write port
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Reads see the stored state, so a write from the previous retire is visible
   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/param_cpu_core.sv
// Single-issue CPU core: fetch, decode and execute in one cycle.
// Fetch handshake: INSTRUCTION is consumed (the instruction retires) at a
// rising edge where INSTR_VALID=1 and the core is in RUN; INSTR_VALID=0 is a
// stall that holds PC, registers, ZERO and state, and there is no ready back
// to the memory (HALTED tells it that nothing more will be consumed).
module param_cpu_core
   import cpu_pkg::*;
#(
   parameter int              DATA_W   = 8,
   parameter int              RA_W     = 3,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       INSTRUCTION,
   input  logic              INSTR_VALID,
   output logic [PC_W-1:0]   PC,
   output logic              WB_EN,
   output logic [RA_W-1:0]   WB_ADDR,
   output logic [DATA_W-1:0] WB_DATA,
   output logic              ZERO,
   output logic              ILLEGAL,
   output logic              HALTED
);

   state_t state;

   logic [OPC_W-1:0]  opcode;
   logic [RA_W-1:0]   dest;
   logic [RA_W-1:0]   src1;
   logic [RA_W-1:0]   src2;
   logic [IMM_W-1:0]  imm_raw;
   logic [OFF_W-1:0]  off_raw;
   logic [DATA_W-1:0] imm_ext;
   logic [PC_W-1:0]   off_ext;

   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_res;

   alu_op_t alu_op;
   logic    wr_reg;
   logic    sets_zero;
   logic    is_jump;
   logic    is_beq;
   logic    is_halt;
   logic    is_illegal;
   logic    retire;

   logic [PC_W-1:0] pc_seq;
   logic [PC_W-1:0] pc_branch;
   logic [PC_W-1:0] next_pc;

   // Not every instruction bit is a field for every RA_W setting
   logic unused_instr_bits;
   assign unused_instr_bits = ^INSTRUCTION;

   // Field extraction
   assign opcode  = INSTRUCTION[OPC_LSB +: OPC_W];
   assign dest    = INSTRUCTION[DEST_LSB +: RA_W];
   assign src1    = INSTRUCTION[SRC1_LSB +: RA_W];
   assign src2    = INSTRUCTION[SRC2_LSB +: RA_W];
   assign imm_raw = INSTRUCTION[IMM_LSB +: IMM_W];
   assign off_raw = INSTRUCTION[OFF_LSB +: OFF_W];

   // Sign-extend immediate and branch offset (offset is shifted after extension)
   assign imm_ext = DATA_W'($signed(imm_raw));
   assign off_ext = PC_W'($signed(off_raw));

   assign retire = (state == ST_RUN) && INSTR_VALID;

   cpu_regfile #(
      .DATA_W (DATA_W),
      .RA_W   (RA_W)
   ) u_regfile (
      .CLK    (CLK),
      .RESET  (RESET),
      .we     (retire && wr_reg),
      .waddr  (dest),
      .wdata  (alu_res),
      .raddr1 (src1),
      .raddr2 (src2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   // Decode opcode into control signals
   always_comb begin
      alu_op     = ALU_PASS;
      wr_reg     = 1'b0;
      sets_zero  = 1'b0;
      is_jump    = 1'b0;
      is_beq     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_LOADI: wr_reg = 1'b1;
         OP_MOV:   wr_reg = 1'b1;
         OP_ADD:   begin alu_op = ALU_ADD; wr_reg = 1'b1; end
         OP_SUB:   begin alu_op = ALU_SUB; wr_reg = 1'b1; end
         OP_AND:   begin alu_op = ALU_AND; wr_reg = 1'b1; end
         OP_OR:    begin alu_op = ALU_OR;  wr_reg = 1'b1; end
         OP_J:     is_jump = 1'b1;
         OP_BEQ:   is_beq  = 1'b1;
         OP_HALT:  is_halt = 1'b1;
         default:  is_illegal = 1'b1;
      endcase
      sets_zero = op_sets_zero(opcode);
   end

   // ALU; loadi passes the immediate, mov passes r[src2]
   always_comb begin
      alu_a   = rdata1;
      alu_b   = (opcode == OP_LOADI) ? imm_ext : rdata2;
      alu_res = alu_b;
      case (alu_op)
         ALU_PASS: alu_res = alu_b;
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a + (~alu_b) + DATA_W'(1);
         ALU_AND:  alu_res = alu_a & alu_b;
         ALU_OR:   alu_res = alu_a | alu_b;
         default:  alu_res = alu_b;
      endcase
   end

   // Next PC: sequential, taken jump/branch, or hold on halt
   always_comb begin
      pc_seq    = PC + PC_W'(4);
      pc_branch = pc_seq + (off_ext << 2);
      next_pc   = pc_seq;
      if (is_jump || (is_beq && (rdata1 == rdata2))) begin
         next_pc = pc_branch;
      end else if (is_halt) begin
         next_pc = PC;
      end
   end

   // Control FSM with registered PC, write-back, flag and status outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_RUN;
         PC      <= RESET_PC;
         WB_EN   <= 1'b0;
         WB_ADDR <= '0;
         WB_DATA <= '0;
         ZERO    <= 1'b0;
         ILLEGAL <= 1'b0;
         HALTED  <= 1'b0;
      end else begin
         WB_EN   <= 1'b0;
         ILLEGAL <= 1'b0;
         case (state)
            ST_RUN: begin
               if (retire) begin
                  PC <= next_pc;
                  if (wr_reg) begin
                     WB_EN   <= 1'b1;
                     WB_ADDR <= dest;
                     WB_DATA <= alu_res;
                  end
                  if (sets_zero) begin
                     ZERO <= (alu_res == '0);
                  end
                  if (is_illegal) begin
                     ILLEGAL <= 1'b1;
                  end
                  if (is_halt) begin
                     state  <= ST_HALT;
                     HALTED <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               HALTED <= 1'b1;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_cpu_core.sv
// Self-checking bench for param_cpu_core with a behavioural ISA model.
module tb_param_cpu_core;

   localparam int              DATA_W   = 8;
   localparam int              RA_W     = 3;
   localparam int              PC_W     = 32;
   localparam logic [PC_W-1:0] RESET_PC = 32'h100;
   localparam int              WBQ_W    = RA_W + DATA_W;

   logic              CLK = 1'b0;
   logic              RESET;
   logic [31:0]       INSTRUCTION;
   logic              INSTR_VALID;
   logic [PC_W-1:0]   PC;
   logic              WB_EN;
   logic [RA_W-1:0]   WB_ADDR;
   logic [DATA_W-1:0] WB_DATA;
   logic              ZERO;
   logic              ILLEGAL;
   logic              HALTED;

   int checks   = 0;
   int failures = 0;

   // Model state
   logic [DATA_W-1:0] m_regs [8];
   logic [PC_W-1:0]   m_pc;
   logic              m_zero;
   logic              m_halted;
   logic              e_wb_en;
   logic [RA_W-1:0]   e_wb_addr;
   logic [DATA_W-1:0] e_wb_data;
   logic              e_ill;

   logic [WBQ_W-1:0] exp_q[$];

   param_cpu_core #(
      .DATA_W   (DATA_W),
      .RA_W     (RA_W),
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_VALID (INSTR_VALID),
      .PC          (PC),
      .WB_EN       (WB_EN),
      .WB_ADDR     (WB_ADDR),
      .WB_DATA     (WB_DATA),
      .ZERO        (ZERO),
      .ILLEGAL     (ILLEGAL),
      .HALTED      (HALTED)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Encoders
   function automatic logic [31:0] enc_r(input logic [7:0] op, input int rd, input int rs1, input int rs2);
      return {op, 8'(rd), 8'(rs1), 8'(rs2)};
   endfunction

   function automatic logic [31:0] enc_i(input logic [7:0] op, input int rd, input logic [7:0] imm);
      return {op, 8'(rd), 8'h00, imm};
   endfunction

   function automatic logic [31:0] enc_b(input logic [7:0] op, input logic [7:0] off, input int rs1, input int rs2);
      return {op, off, 8'(rs1), 8'(rs2)};
   endfunction

   task automatic model_write(input int rd, input logic [DATA_W-1:0] v);
      m_regs[rd] = v;
      e_wb_en    = 1'b1;
      e_wb_addr  = RA_W'(rd);
      e_wb_data  = v;
   endtask

   // Drive one cycle, advance the ISA model, sample 1 time unit after the edge
   task automatic issue(input logic [31:0] instr, input logic valid);
      logic [7:0]  op;
      int          rd, s1, s2, off;
      logic [DATA_W-1:0] a, b, v;
      logic [PC_W-1:0] nxt;
      INSTRUCTION = instr;
      INSTR_VALID = valid;
      e_wb_en = 1'b0;
      e_ill   = 1'b0;
      if (!m_halted && valid) begin
         op  = instr[31:24];
         rd  = int'(instr[18:16]);
         s1  = int'(instr[10:8]);
         s2  = int'(instr[2:0]);
         off = int'($signed(instr[23:16]));
         a   = m_regs[s1];
         b   = m_regs[s2];
         nxt = m_pc + 32'd4;
         case (op)
            8'h00: model_write(rd, instr[7:0]);
            8'h01: model_write(rd, b);
            8'h02: begin v = a + b; model_write(rd, v); m_zero = (v == 0); end
            8'h03: begin v = a - b; model_write(rd, v); m_zero = (v == 0); end
            8'h04: begin v = a & b; model_write(rd, v); m_zero = (v == 0); end
            8'h05: begin v = a | b; model_write(rd, v); m_zero = (v == 0); end
            8'h06: nxt = m_pc + 32'd4 + 32'(off * 4);
            8'h07: if (a == b) nxt = m_pc + 32'd4 + 32'(off * 4);
            8'hFF: begin m_halted = 1'b1; nxt = m_pc; end
            default: e_ill = 1'b1;
         endcase
         m_pc = nxt;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET       = 1'b1;
      INSTR_VALID = 1'b1;
      INSTRUCTION = enc_i(8'h00, 1, 8'h55);
      @(posedge CLK);
      #1;
      RESET       = 1'b0;
      INSTR_VALID = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pc      = RESET_PC;
      m_zero    = 1'b0;
      m_halted  = 1'b0;
      e_wb_en   = 1'b0;
      e_wb_addr = '0;
      e_wb_data = '0;
      e_ill     = 1'b0;
   endtask

   // Jump to target with a j instruction and confirm arrival
   task automatic goto_pc(input logic [PC_W-1:0] target);
      int off;
      off = (int'(target) - int'(m_pc) - 4) / 4;
      issue(enc_b(8'h06, 8'(off), 0, 0), 1'b1);
      checks++;
      if (PC !== target) begin
         failures++;
         $display("FAIL goto_pc: PC=%h expected %h", PC, target);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 7;
      if (PC !== 32'h100) begin failures++; $display("FAIL reset_pc: got %h exp 100", PC); end
      if (HALTED !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b exp 0", HALTED); end
      if (WB_EN !== 1'b0) begin failures++; $display("FAIL reset_wb_en: got %b exp 0", WB_EN); end
      if (WB_ADDR !== '0) begin failures++; $display("FAIL reset_wb_addr: got %h exp 0", WB_ADDR); end
      if (WB_DATA !== '0) begin failures++; $display("FAIL reset_wb_data: got %h exp 0", WB_DATA); end
      if (ZERO !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b exp 0", ZERO); end
      if (ILLEGAL !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b exp 0", ILLEGAL); end
      // Dirty registers, then reset again and confirm every register reads 0
      for (int i = 0; i < 8; i++) issue(enc_i(8'h00, i, 8'(8'hA0 + i)), 1'b1);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         issue(enc_r(8'h01, i, 0, i), 1'b1);
         checks++;
         if (WB_EN !== 1'b1 || WB_DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_reg r%0d: wb_en=%b data=%h exp 1/00", i, WB_EN, WB_DATA);
         end
      end
   endtask

   task automatic test_alu_seq();
      do_reset();
      issue(enc_i(8'h00, 1, 8'h05), 1'b1);
      checks++;
      if (WB_EN !== 1'b1 || WB_ADDR !== 3'd1 || WB_DATA !== 8'h05 || PC !== 32'h104) begin
         failures++;
         $display("FAIL loadi_r1: en=%b addr=%0d data=%h pc=%h exp 1/1/05/104", WB_EN, WB_ADDR, WB_DATA, PC);
      end
      issue(enc_i(8'h00, 2, 8'h03), 1'b1);
      issue(enc_r(8'h03, 3, 1, 2), 1'b1);
      checks++;
      if (WB_ADDR !== 3'd3 || WB_DATA !== 8'h02 || ZERO !== 1'b0 || PC !== 32'h10C) begin
         failures++;
         $display("FAIL sub_r3: addr=%0d data=%h zero=%b pc=%h exp 3/02/0/10c", WB_ADDR, WB_DATA, ZERO, PC);
      end
      issue(enc_r(8'h03, 4, 2, 2), 1'b1);
      checks++;
      if (WB_DATA !== 8'h00 || ZERO !== 1'b1 || PC !== 32'h110) begin
         failures++;
         $display("FAIL sub_r4: data=%h zero=%b pc=%h exp 00/1/110", WB_DATA, ZERO, PC);
      end
      // Negative immediate sign-extends; and/or results
      issue(enc_i(8'h00, 5, 8'hF0), 1'b1);
      issue(enc_i(8'h00, 6, 8'h3C), 1'b1);
      issue(enc_r(8'h04, 7, 5, 6), 1'b1);
      checks++;
      if (WB_DATA !== 8'h30 || ZERO !== 1'b0) begin
         failures++;
         $display("FAIL and_r7: data=%h zero=%b exp 30/0", WB_DATA, ZERO);
      end
      issue(enc_r(8'h05, 0, 5, 6), 1'b1);
      checks++;
      if (WB_ADDR !== 3'd0 || WB_DATA !== 8'hFC) begin
         failures++;
         $display("FAIL or_r0: addr=%0d data=%h exp 0/fc", WB_ADDR, WB_DATA);
      end
   endtask

   task automatic test_stall();
      logic [PC_W-1:0] p0;
      p0 = m_pc;
      for (int i = 0; i < 3; i++) begin
         issue(enc_i(8'h00, 1, 8'h7F), 1'b0);
         checks++;
         if (PC !== p0 || WB_EN !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold %0d: pc=%h wb_en=%b exp %h/0", i, PC, WB_EN, p0);
         end
      end
      issue(enc_i(8'h00, 1, 8'h7F), 1'b1);
      checks++;
      if (WB_EN !== 1'b1 || WB_ADDR !== 3'd1 || WB_DATA !== 8'h7F || PC !== p0 + 32'd4) begin
         failures++;
         $display("FAIL stall_release: en=%b addr=%0d data=%h pc=%h exp 1/1/7f/%h", WB_EN, WB_ADDR, WB_DATA, PC, p0 + 32'd4);
      end
      issue(enc_i(8'h00, 1, 8'h7F), 1'b0);
      checks++;
      if (WB_EN !== 1'b0 || PC !== p0 + 32'd4) begin
         failures++;
         $display("FAIL stall_single_pulse: en=%b pc=%h exp 0/%h", WB_EN, PC, p0 + 32'd4);
      end
   endtask

   task automatic test_branches();
      do_reset();
      issue(enc_i(8'h00, 1, 8'h09), 1'b1);
      issue(enc_i(8'h00, 2, 8'h09), 1'b1);
      goto_pc(32'h20);
      issue(enc_b(8'h07, 8'hFE, 1, 2), 1'b1);
      checks++;
      if (PC !== 32'h1C || WB_EN !== 1'b0) begin
         failures++;
         $display("FAIL beq_taken: pc=%h wb_en=%b exp 1c/0", PC, WB_EN);
      end
      issue(enc_i(8'h00, 2, 8'h04), 1'b1);
      checks++;
      if (PC !== 32'h20) begin failures++; $display("FAIL beq_setup: pc=%h exp 20", PC); end
      issue(enc_b(8'h07, 8'hFE, 1, 2), 1'b1);
      checks++;
      if (PC !== 32'h24) begin failures++; $display("FAIL beq_not_taken: pc=%h exp 24", PC); end
      goto_pc(32'h40);
      issue(enc_b(8'h06, 8'h03, 0, 0), 1'b1);
      checks++;
      if (PC !== 32'h50) begin failures++; $display("FAIL j_fwd: pc=%h exp 50", PC); end
   endtask

   task automatic test_wrap_illegal();
      logic [PC_W-1:0] p0;
      issue(enc_i(8'h00, 1, 8'hFF), 1'b1);
      issue(enc_i(8'h00, 2, 8'h01), 1'b1);
      issue(enc_r(8'h02, 3, 1, 2), 1'b1);
      checks++;
      if (WB_EN !== 1'b1 || WB_DATA !== 8'h00 || ZERO !== 1'b1 || ILLEGAL !== 1'b0) begin
         failures++;
         $display("FAIL add_wrap: en=%b data=%h zero=%b ill=%b exp 1/00/1/0", WB_EN, WB_DATA, ZERO, ILLEGAL);
      end
      p0 = m_pc;
      issue(32'h42123456, 1'b1);
      checks++;
      if (ILLEGAL !== 1'b1 || WB_EN !== 1'b0 || PC !== p0 + 32'd4 || ZERO !== 1'b1) begin
         failures++;
         $display("FAIL illegal: ill=%b en=%b pc=%h zero=%b exp 1/0/%h/1", ILLEGAL, WB_EN, PC, ZERO, p0 + 32'd4);
      end
      issue(32'h42000000, 1'b0);
      checks++;
      if (ILLEGAL !== 1'b0) begin failures++; $display("FAIL illegal_pulse: ill=%b exp 0", ILLEGAL); end
      issue(32'h42000000, 1'b1);
      issue(32'h43000000, 1'b1);
      checks++;
      if (ILLEGAL !== 1'b1) begin failures++; $display("FAIL illegal_b2b: ill=%b exp 1", ILLEGAL); end
   endtask

   task automatic test_halt();
      do_reset();
      goto_pc(32'h30);
      issue(32'hFF000000, 1'b0);
      checks++;
      if (HALTED !== 1'b0 || PC !== 32'h30) begin
         failures++;
         $display("FAIL halt_stalled: halted=%b pc=%h exp 0/30", HALTED, PC);
      end
      issue(32'hFF000000, 1'b1);
      checks++;
      if (HALTED !== 1'b1 || PC !== 32'h30 || WB_EN !== 1'b0) begin
         failures++;
         $display("FAIL halt_enter: halted=%b pc=%h en=%b exp 1/30/0", HALTED, PC, WB_EN);
      end
      for (int i = 0; i < 5; i++) begin
         issue(enc_i(8'h00, 1, 8'h11), 1'b1);
         checks++;
         if (HALTED !== 1'b1 || PC !== 32'h30 || WB_EN !== 1'b0 || ILLEGAL !== 1'b0) begin
            failures++;
            $display("FAIL halt_hold %0d: halted=%b pc=%h en=%b ill=%b exp 1/30/0/0", i, HALTED, PC, WB_EN, ILLEGAL);
         end
      end
      do_reset();
      checks++;
      if (HALTED !== 1'b0 || PC !== 32'h100) begin
         failures++;
         $display("FAIL halt_reset: halted=%b pc=%h exp 0/100", HALTED, PC);
      end
      issue(enc_i(8'h00, 0, 8'h22), 1'b1);
      checks++;
      if (WB_EN !== 1'b1 || WB_DATA !== 8'h22 || PC !== 32'h104) begin
         failures++;
         $display("FAIL halt_resume: en=%b data=%h pc=%h exp 1/22/104", WB_EN, WB_DATA, PC);
      end
   endtask

   task automatic test_random();
      logic [7:0]  op;
      logic [31:0] instr;
      logic        valid;
      logic [WBQ_W-1:0] got, exp;
      do_reset();
      exp_q.delete();
      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    op = 8'h00;
            2:       op = 8'h01;
            3:       op = 8'h02;
            4:       op = 8'h03;
            5:       op = 8'h04;
            6:       op = 8'h05;
            7:       op = 8'h06;
            8:       op = 8'h07;
            default: op = 8'($urandom_range(8, 254));
         endcase
         instr = {op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
         valid = ($urandom_range(0, 3) != 0);
         issue(instr, valid);
         if (e_wb_en) exp_q.push_back({e_wb_addr, e_wb_data});
         checks++;
         if (PC !== m_pc || ZERO !== m_zero || HALTED !== m_halted || ILLEGAL !== e_ill || WB_EN !== e_wb_en) begin
            failures++;
            $display("FAIL random %0d: pc=%h zero=%b halted=%b ill=%b en=%b exp %h/%b/%b/%b/%b",
                     n, PC, ZERO, HALTED, ILLEGAL, WB_EN, m_pc, m_zero, m_halted, e_ill, e_wb_en);
         end
         if (WB_EN === 1'b1) begin
            got = {WB_ADDR, WB_DATA};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL random_wb %0d: unexpected write %h", n, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  failures++;
                  $display("FAIL random_wb %0d: got %h exp %h", n, got, exp);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL random_wb_drain: %0d writes missing, exp 0", exp_q.size());
      end
   endtask

   initial begin
      RESET       = 1'b1;
      INSTR_VALID = 1'b0;
      INSTRUCTION = '0;
      test_reset();
      test_alu_seq();
      test_stall();
      test_branches();
      test_wrap_illegal();
      test_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
